// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART TX shifter.
// The master side is the requesters plus the transmitter. The slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte port among N_REQ requesters.
// A grant is held for a whole message, so messages never interleave on the line.
// A stalled owner is released after TIMEOUT_CYC idle cycles. A value of 0 disables the timeout.
module uart_tx_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_arbiter_if.slave        bus,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    timeout_evt_o
);
    localparam int              PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]  NREQ_W   = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [15:0]     TMO      = 16'(TIMEOUT_CYC);

    typedef enum logic {IDLE, OWN} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
    logic [15:0]        stallCnt_q, stallCnt_d;

    logic [PTR_W-1:0]   pickIdx;
    logic [PTR_W:0]     candSum;
    logic [PTR_W-1:0]   candIdx;
    logic               ownerValid;
    logic               ownerLast;
    logic [7:0]         ownerData;
    logic               xfer;
    logic               lastXfer;
    logic               timeoutHit;

    // Find the first valid requester at or after rrPtr_q. The loop runs downward so the nearest candidate wins.
    always_comb begin
        pickIdx = rrPtr_q;
        candSum = '0;
        candIdx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            candSum = {1'b0, rrPtr_q} + (PTR_W+1)'(k);
            if (candSum >= NREQ_W) begin
                candSum = candSum - NREQ_W;
            end
            candIdx = candSum[PTR_W-1:0];
            if (bus.req_valid[candIdx]) begin
                pickIdx = candIdx;
            end
        end
    end

    // Select the current owner's byte, valid and last flags from the registered owner index.
    always_comb begin
        ownerValid = 1'b0;
        ownerLast  = 1'b0;
        ownerData  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == PTR_W'(k)) begin
                ownerValid = bus.req_valid[k];
                ownerLast  = bus.req_last[k];
                ownerData  = bus.req_data[8*k +: 8];
            end
        end
    end

    // Next-state and output logic: arbitration in IDLE, pass-through and release in OWN.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rrPtr_d       = rrPtr_q;
        stallCnt_d    = stallCnt_q;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus.req_ready = '0;
        xfer          = 1'b0;
        lastXfer      = 1'b0;
        timeoutHit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d          = OWN;
                    owner_d          = pickIdx;
                    grant_d          = '0;
                    grant_d[pickIdx] = 1'b1;
                    stallCnt_d       = '0;
                end
            end
            OWN: begin
                bus.tx_valid  = ownerValid;
                bus.tx_data   = ownerData;
                bus.req_ready = grant_q & {N_REQ{bus.tx_ready}};
                xfer          = ownerValid && bus.tx_ready;
                lastXfer      = xfer && ownerLast;
                timeoutHit    = (TMO != 16'd0) && (stallCnt_q >= TMO) && !lastXfer;
                if (xfer) begin
                    stallCnt_d = '0;
                end else if (!ownerValid && (stallCnt_q != 16'hFFFF)) begin
                    stallCnt_d = stallCnt_q + 16'd1;
                end
                if (lastXfer || timeoutHit) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    stallCnt_d = '0;
                    rrPtr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset. A reset mid-message drops the partial message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rrPtr_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rrPtr_q    <= rrPtr_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign grant_o       = grant_q;
    assign timeout_evt_o = timeoutHit;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with four requesters and a 16-cycle timeout.
// Directed message sequences are checked first, then randomized traffic with random resets.
// A behavioural owner/pointer/idle-run model predicts every output on every cycle.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [N-1:0] grant;
    logic       timeoutEvt;
    logic       checkEn = 1'b0;

    int nVec = 0;
    int nErr = 0;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .grant_o       (grant),
        .timeout_evt_o (timeoutEvt)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    // Compare one observed value against the expected one and count the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one requester's valid, byte and last flag.
    task automatic setReq(input int k, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid[k]        = v;
        bus.req_data[8*k +: 8]  = d;
        bus.req_last[k]         = l;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state: current owner (-1 when idle), round-robin start, and the owner's idle run.
    int mOwner = -1;
    int mPtr   = 0;
    int mIdle  = 0;
    int pick;
    logic [N-1:0] eGrant, eReady;
    logic         eTxv, eXfer, eLast, eTmo;
    logic [7:0]   eData;

    // Predict outputs from the model at the falling edge, compare them, then advance the model across the next rising edge.
    always @(negedge clk) begin
        if (checkEn) begin
            eGrant = '0;
            eReady = '0;
            eTxv   = 1'b0;
            eData  = '0;
            eXfer  = 1'b0;
            eLast  = 1'b0;
            eTmo   = 1'b0;
            if (mOwner >= 0) begin
                eGrant[mOwner] = 1'b1;
                eTxv           = bus.req_valid[mOwner];
                eData          = bus.req_data[8*mOwner +: 8];
                eReady[mOwner] = bus.tx_ready;
                eXfer          = eTxv && bus.tx_ready;
                eLast          = eXfer && bus.req_last[mOwner];
                eTmo           = (mIdle >= TMO) && !eLast;
            end
            checkOutput("grant", 32'(grant), 32'(eGrant));
            checkOutput("tx_valid", 32'(bus.tx_valid), 32'(eTxv));
            checkOutput("req_ready", 32'(bus.req_ready), 32'(eReady));
            checkOutput("timeout_evt", 32'(timeoutEvt), 32'(eTmo));
            if (eTxv) begin
                checkOutput("tx_data", 32'(bus.tx_data), 32'(eData));
            end
            if (rst) begin
                mOwner = -1;
                mPtr   = 0;
                mIdle  = 0;
            end else if (mOwner < 0) begin
                pick = -1;
                for (int j = N - 1; j >= 0; j--) begin
                    if (bus.req_valid[(mPtr + j) % N]) pick = (mPtr + j) % N;
                end
                if (pick >= 0) begin
                    mOwner = pick;
                    mIdle  = 0;
                end
            end else if (eLast || eTmo) begin
                mPtr   = (mOwner + 1) % N;
                mOwner = -1;
                mIdle  = 0;
            end else if (eXfer) begin
                mIdle = 0;
            end else if (!eTxv && mIdle < 65535) begin
                mIdle++;
            end
        end
    end

    logic [16:0] evtHist;
    int          evtCnt;
    int          remaining [N];
    int          gap [N];
    logic [N-1:0] acc;

    // Run the directed sequences and the random traffic, pinning key cycles with literal expectations.
    task automatic applyStimulus();
        // Reset
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        tick();
        checkEn = 1'b1;
        tick();
        rst = 1'b0;

        // Requester 0 sends 41 42 0A, last on 0A
        bus.tx_ready = 1'b1;
        setReq(0, 1'b1, 8'h41, 1'b0);
        @(negedge clk);
        checkOutput("A idle grant", 32'(grant), 32'h0);
        checkOutput("A idle tx_valid", 32'(bus.tx_valid), 32'h0);
        tick(); @(negedge clk);
        checkOutput("A grant", 32'(grant), 32'h1);
        checkOutput("A byte0", 32'(bus.tx_data), 32'h41);
        checkOutput("A ready", 32'(bus.req_ready), 32'h1);
        tick(); setReq(0, 1'b1, 8'h42, 1'b0); @(negedge clk);
        checkOutput("A byte1", 32'(bus.tx_data), 32'h42);
        tick(); setReq(0, 1'b1, 8'h0A, 1'b1); @(negedge clk);
        checkOutput("A byte2", 32'(bus.tx_data), 32'h0A);
        checkOutput("A grant last", 32'(grant), 32'h1);
        tick(); setReq(0, 1'b0, 8'h00, 1'b0); @(negedge clk);
        checkOutput("A released", 32'(grant), 32'h0);
        checkOutput("A released tx_valid", 32'(bus.tx_valid), 32'h0);

        // Owner 0 sends one non-last byte, then stalls until the timeout
        tick(); setReq(0, 1'b1, 8'h55, 1'b0); @(negedge clk);
        tick(); @(negedge clk);
        checkOutput("B grant", 32'(grant), 32'h1);
        checkOutput("B byte", 32'(bus.tx_data), 32'h55);
        tick(); setReq(0, 1'b0, 8'h00, 1'b0); setReq(1, 1'b1, 8'h66, 1'b1);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            evtHist[i] = timeoutEvt;
            if (i < 16) tick();
        end
        checkOutput("B timeout timing", 32'(evtHist), 32'h10000);
        tick(); @(negedge clk);
        checkOutput("B released", 32'(grant), 32'h0);
        tick(); @(negedge clk);
        checkOutput("B next owner", 32'(grant), 32'h2);
        checkOutput("B next byte", 32'(bus.tx_data), 32'h66);
        tick(); setReq(1, 1'b0, 8'h00, 1'b0); @(negedge clk);

        // Pointer at 2 with requesters 1 and 3 valid: 3 is granted first, then 1 after wrapping
        tick(); setReq(1, 1'b1, 8'h31, 1'b1); setReq(3, 1'b1, 8'h33, 1'b1); @(negedge clk);
        tick(); @(negedge clk);
        checkOutput("C first", 32'(grant), 32'h8);
        checkOutput("C first byte", 32'(bus.tx_data), 32'h33);
        checkOutput("C held off", 32'(bus.req_ready), 32'h8);
        tick(); setReq(3, 1'b0, 8'h00, 1'b0); @(negedge clk);
        checkOutput("C gap", 32'(grant), 32'h0);
        tick(); @(negedge clk);
        checkOutput("C wrap", 32'(grant), 32'h2);
        checkOutput("C wrap byte", 32'(bus.tx_data), 32'h31);
        tick(); setReq(1, 1'b0, 8'h00, 1'b0); @(negedge clk);

        // Back-pressure for 100 cycles with the owner valid never times out
        tick(); bus.tx_ready = 1'b0; setReq(2, 1'b1, 8'h77, 1'b1); @(negedge clk);
        evtCnt = 0;
        repeat (100) begin
            tick(); @(negedge clk);
            evtCnt += int'(timeoutEvt);
        end
        checkOutput("D no timeout", 32'(evtCnt), 32'h0);
        checkOutput("D still owner", 32'(grant), 32'h4);
        tick(); bus.tx_ready = 1'b1; @(negedge clk);
        checkOutput("D byte", 32'(bus.tx_data), 32'h77);
        tick(); setReq(2, 1'b0, 8'h00, 1'b0); @(negedge clk);

        // Reset mid-message of owner 1, then requester 0 wins from pointer 0
        tick(); setReq(1, 1'b1, 8'h81, 1'b0); @(negedge clk);
        tick(); @(negedge clk);
        checkOutput("E owner", 32'(grant), 32'h2);
        tick(); setReq(1, 1'b1, 8'h82, 1'b0); setReq(0, 1'b1, 8'h01, 1'b0); rst = 1'b1; @(negedge clk);
        tick(); rst = 1'b0; @(negedge clk);
        checkOutput("E reset grant", 32'(grant), 32'h0);
        checkOutput("E reset tx_valid", 32'(bus.tx_valid), 32'h0);
        tick(); @(negedge clk);
        checkOutput("E ptr restart", 32'(grant), 32'h1);
        tick(); bus.req_valid = '0; bus.req_last = '0;

        // Random traffic: each requester holds a byte until accepted and may pause between bytes
        for (int k = 0; k < N; k++) begin
            remaining[k] = 0;
            gap[k]       = 0;
        end
        repeat (3000) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            tick();
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    remaining[k]--;
                    bus.req_valid[k] = 1'b0;
                    gap[k] = ($urandom % 8 == 0) ? int'($urandom_range(12, 22)) : int'($urandom_range(0, 2));
                end
                if (!bus.req_valid[k]) begin
                    if (gap[k] > 0) begin
                        gap[k]--;
                    end else begin
                        if (remaining[k] == 0 && $urandom % 4 == 0) remaining[k] = int'($urandom_range(1, 4));
                        if (remaining[k] > 0) setReq(k, 1'b1, 8'($urandom), remaining[k] == 1);
                    end
                end
            end
            bus.tx_ready = ($urandom % 4) != 0;
            rst          = ($urandom % 400) == 0;
        end
        rst = 1'b0;
    endtask

    // Print the single summary line.
    task automatic checkOutputSummary();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    endtask

    initial begin
        applyStimulus();
        @(negedge clk);
        checkEn = 1'b0;
        checkOutputSummary();
        $finish;
    end
endmodule
